// File: rtl/alu_shift_seq_pkg.sv
// Shared ALU control definitions for the CB rotate/shift micro-sequencer.
// Holds the control-word layout, its field encodings and the fixed control words.
package alu_shift_seq_pkg;

  typedef enum logic {
    R_SH = 1'b0,
    L_SH = 1'b1
  } sh_t;

  typedef enum logic {
    SH_OE  = 1'b0,
    RES_OE = 1'b1
  } oe_t;

  typedef enum logic {
    BUS_LD = 1'b0,
    NO_LD  = 1'b1
  } ld_t;

  // CB opcode bits [5:3]
  typedef enum logic [2:0] {
    OP_RLC  = 3'd0,
    OP_RRC  = 3'd1,
    OP_RL   = 3'd2,
    OP_RR   = 3'd3,
    OP_SLA  = 3'd4,
    OP_SRA  = 3'd5,
    OP_SWAP = 3'd6,
    OP_SRL  = 3'd7
  } opsel_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RES  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [7:0] op;
    logic       si;
    sh_t        sh;
    oe_t        oe;
    ld_t        la;
    ld_t        lb;
    logic       r;
    logic       s;
    logic       v;
    logic       ne;
    logic       ci;
    logic       l;
    logic       h;
  } alu_ctl_t;

  localparam alu_ctl_t ALU_CTL_IDLE = '{
    op: 8'h00, si: 1'b0, sh: R_SH, oe: RES_OE, la: NO_LD, lb: NO_LD,
    r: 1'b0, s: 1'b0, v: 1'b0, ne: 1'b0, ci: 1'b0, l: 1'b0, h: 1'b0
  };

  localparam alu_ctl_t ALU_CTL_RES = '{
    op: 8'h00, si: 1'b0, sh: R_SH, oe: RES_OE, la: NO_LD, lb: NO_LD,
    r: 1'b1, s: 1'b1, v: 1'b1, ne: 1'b0, ci: 1'b0, l: 1'b0, h: 1'b1
  };

  // Load/shift cycle: operand onto both ALU latches, shifter output enabled.
  function automatic alu_ctl_t load_ctl(logic [7:0] operand, logic si, sh_t sh);
    alu_ctl_t c;
    c    = ALU_CTL_IDLE;
    c.op = operand;
    c.si = si;
    c.sh = sh;
    c.oe = SH_OE;
    c.la = BUS_LD;
    c.lb = BUS_LD;
    c.r  = 1'b1;
    c.s  = 1'b1;
    c.v  = 1'b1;
    c.l  = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/alu_shift_seq_if.sv
// Decoder-side request/response and ALU-side control/status bundle of the sequencer.
interface alu_shift_seq_if;
  import alu_shift_seq_pkg::*;

  logic       start;
  logic       ready;
  logic [2:0] opsel;
  logic [7:0] operand;
  logic       carry_in;
  alu_ctl_t   alu_ctl;
  logic       alu_shift_dbl;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       done;
  logic [7:0] res;
  logic [3:0] flags;
  logic       err;

  modport slave (
    input  start, opsel, operand, carry_in, alu_shift_dbl, alu_result, alu_zero,
    output ready, alu_ctl, done, res, flags, err
  );

  modport master (
    output start, opsel, operand, carry_in, alu_shift_dbl, alu_result, alu_zero,
    input  ready, alu_ctl, done, res, flags, err
  );

endinterface

// File: rtl/alu_shift_seq_shift_si_sel.sv
// Shift-in bit and shift direction for each rotate/shift opcode.
module shift_si_sel
  import alu_shift_seq_pkg::*;
(
  input  opsel_t     i_opsel,
  input  logic [7:0] i_operand,
  input  logic       i_carry,
  output logic       o_si,
  output sh_t        o_sh
);

  always_comb begin
    o_si = 1'b0;
    o_sh = L_SH;
    case (i_opsel)
      OP_RLC: begin
        o_si = i_operand[7];
        o_sh = L_SH;
      end
      OP_RRC: begin
        o_si = i_operand[0];
        o_sh = R_SH;
      end
      OP_RL: begin
        o_si = i_carry;
        o_sh = L_SH;
      end
      OP_RR: begin
        o_si = i_carry;
        o_sh = R_SH;
      end
      OP_SLA: begin
        o_si = 1'b0;
        o_sh = L_SH;
      end
      // Arithmetic right shift replicates the sign bit.
      OP_SRA: begin
        o_si = i_operand[7];
        o_sh = R_SH;
      end
      OP_SRL: begin
        o_si = 1'b0;
        o_sh = R_SH;
      end
      default: begin
        o_si = 1'b0;
        o_sh = L_SH;
      end
    endcase
  end

endmodule

// File: rtl/alu_shift_seq.sv
// CB rotate/shift micro-sequencer: issues LOAD then RES ALU control words,
// captures carry, result and zero, and returns the byte plus {Z,N,H,C}.
module alu_shift_seq
  import alu_shift_seq_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  alu_shift_seq_if.slave  io_bus
);

  seq_state_t r_state;
  seq_state_t w_state_next;
  logic [7:0] r_operand;
  opsel_t     r_opsel;
  logic       r_carry;
  logic       r_c_shift;
  logic [7:0] r_res;
  logic [3:0] r_flags;
  logic       r_err;

  logic       w_ready;
  logic       w_req;
  logic       w_bad_op;
  logic       w_accept;
  logic       w_si;
  sh_t        w_sh;
  alu_ctl_t   w_ctl;

  assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_req    = io_bus.start && w_ready;
  assign w_bad_op = (io_bus.opsel == OP_SWAP);
  assign w_accept = w_req && !w_bad_op;

  shift_si_sel u_si_sel (
    .i_opsel   (r_opsel),
    .i_operand (r_operand),
    .i_carry   (r_carry),
    .o_si      (w_si),
    .o_sh      (w_sh)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Control word depends only on state and latched operands, never on start.
  always_comb begin
    w_state_next = r_state;
    w_ctl        = ALU_CTL_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_state_next = ST_RES;
        w_ctl        = load_ctl(r_operand, w_si, w_sh);
      end
      ST_RES: begin
        w_state_next = ST_DONE;
        w_ctl        = ALU_CTL_RES;
      end
      ST_DONE: begin
        w_state_next = w_accept ? ST_LOAD : ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_operand <= 8'h00;
      r_opsel   <= OP_RLC;
      r_carry   <= 1'b0;
      r_c_shift <= 1'b0;
      r_res     <= 8'h00;
      r_flags   <= 4'h0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_req && w_bad_op;
      if (w_accept) begin
        r_operand <= io_bus.operand;
        r_opsel   <= opsel_t'(io_bus.opsel);
        r_carry   <= io_bus.carry_in;
      end
      if (r_state == ST_LOAD) begin
        r_c_shift <= io_bus.alu_shift_dbl;
      end
      // Carry is staged so visible flags change only together with the result.
      if (r_state == ST_RES) begin
        r_res   <= io_bus.alu_result;
        r_flags <= {io_bus.alu_zero, 1'b0, 1'b0, r_c_shift};
      end
    end
  end

  assign io_bus.ready   = w_ready;
  assign io_bus.alu_ctl = w_ctl;
  assign io_bus.done    = (r_state == ST_DONE);
  assign io_bus.res     = r_res;
  assign io_bus.flags   = r_flags;
  assign io_bus.err     = r_err;

endmodule

// File: doc/alu_shift_seq.md
# alu_shift_seq

Micro-sequencer that drives the ALU control word for the CB-prefix rotate/shift group (RLC, RRC, RL, RR, SLA, SRA, SRL). It accepts one operation from the instruction decoder and issues the two-cycle ALU control sequence: a load/shift cycle, then a result cycle. It captures the shifted-out bit, result and zero flag from the ALU and returns the byte and the F flags to the register file. It sits between the CB decoder and the ALU and initiates what the ALU responds to.

## Interface
- No parameters.
- `clk` in 1: system clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; accepted when `start && ready`.
- `ready` out 1: can accept a request this cycle.
- `opsel` in 3: CB opcode bits [5:3]. 0=RLC, 1=RRC, 2=RL, 3=RR, 4=SLA, 5=SRA, 6=SWAP (unsupported), 7=SRL.
- `operand` in 8: byte to shift; sampled at accept.
- `carry_in` in 1: current F.C; sampled at accept.
- `alu_ctl` out `alu_ctl_t`: ALU control word with fields op, si, sh, oe, la, lb, r, s, v, ne, ci, l, h.
- `alu_shift_dbl` in 1: ALU shifted-out bit, valid in LOAD cycle.
- `alu_result` in 8, `alu_zero` in 1: ALU outputs, valid in RES cycle.
- `done` out 1: one-cycle pulse; `res`/`flags` valid.
- `res` out 8: shifted byte.
- `flags` out 4: {Z,N,H,C}.
- `err` out 1: one-cycle pulse when `opsel`=6 is presented with `start && ready`.

## Operation
- FSM states: IDLE, LOAD, RES, DONE.
- IDLE→LOAD on accept. Latch operand, opsel, carry_in.
- LOAD→RES unconditionally. RES→DONE unconditionally.
- DONE→LOAD on accept; otherwise DONE→IDLE.
- `ready` = state∈{IDLE,DONE}.
- opsel=6 with `start && ready`: pulse `err` next cycle. The request is not accepted and the state stays or returns to IDLE.
- LOAD drives `alu_ctl`:
  - op=operand, sh=R_SH for RRC/RR/SRA/SRL and L_SH otherwise, oe=SH_OE, la=lb=BUS_LD.
  - r=s=v=1, ne=0, ci=0, l=1, h=0.
  - si: RLC=operand[7], RRC=operand[0], RL/RR=carry_in, SLA=0, SRA=operand[7], SRL=0.
- LOAD captures `alu_shift_dbl` as C.
- RES drives `alu_ctl`:
  - la=lb=NO_LD, oe=RES_OE.
  - r=s=v=1, ne=0, ci=0, l=0, h=1.
  - op=0, si=0, sh=R_SH.
- RES captures `alu_result` into `res` and `alu_zero` into Z.
- IDLE and DONE drive the package constant ALU_CTL_IDLE: la=lb=NO_LD, oe=RES_OE, all 1-bit fields 0, op=0, sh=R_SH.
- In DONE: `done`=1, flags={Z,0,0,C}.
- `res`/`flags` hold their values until the next RES capture.

## Timing
- Accept at edge N. LOAD during cycle N+1, RES during N+2, `done` during N+3.
- Back-to-back throughput: one operation per 3 cycles (accept in DONE).
- `alu_ctl` is registered-state decode, combinational from state plus latched operands. It has no dependency on `start` in the same cycle.
- Reset values: state=IDLE, ready=1, done=0, err=0, res=0x00, flags=0x0, alu_ctl=ALU_CTL_IDLE.
- Reset asserted mid-operation: immediate return to IDLE and ALU_CTL_IDLE. No `done` for the aborted operation.
- `start` while not ready: ignored, no latching, no `err`.

## Structure
- Shared ALU package holds:
  - `alu_ctl_t` packed struct.
  - Enums for sh (R_SH, L_SH), oe (SH_OE, RES_OE), and ld (BUS_LD, NO_LD).
  - ALU_CTL_IDLE constant.
  - Enum for opsel encodings.
- One natural sub-module, `shift_si_sel`: combinational si/direction select from opsel, operand and carry_in.
- The FSM stays in the top.

## Test plan
- RRC operand=0x01 → LOAD: si=1, sh=R_SH, shift_dbl captured 1; `done` at N+3, res=0x80, flags=0b0001.
- RLC 0x80 → si=1, sh=L_SH; res=0x01, flags=0b0001.
- RL 0x80, carry_in=0 → si=0; res=0x00, flags=0b1001. Repeat with carry_in=1 → res=0x01, flags=0b0001.
- SRA 0x81 → si=1; res=0xC0, C=1. SRL 0x81 → res=0x40, C=1. SLA 0x40 → res=0x80, C=0.
- opsel=6 with start in IDLE → `err`=1 one cycle, ready stays 1, alu_ctl stays ALU_CTL_IDLE, no `done`.
- reset_n low during RES → same-cycle ALU_CTL_IDLE, ready=1, no `done`. Back-to-back start in DONE → second `done` exactly 3 cycles after the first.
